memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//   MEM stage of the 5-stage MIPS pipeline; consumer of the EX/MEM register outputs.
//   Resolves WB->MEM forwarding of store data and performs data-memory stores/loads.
//   Sign/zero-extends load data and registers it into the MEM/WB pipeline register.
//   Also carries PC, Instr, ALU result, write address and immediate forward to the WB stage.
// PARAMETERS
//   DM_WORDS   1024  data-memory depth in 32-bit words (power of two)
//   DM_AW      10    word-index width, log2(DM_WORDS)
// PORTS
//   clk         in   1   rising-edge clock
//   reset       in   1   synchronous, active-high reset
//   PC3         in   32  EX/MEM PC
//   Instr3      in   32  EX/MEM instruction
//   Result3     in   32  EX/MEM ALU result; byte address for loads/stores
//   B3          in   32  EX/MEM store data, before forwarding
//   WA3         in   5   EX/MEM destination register
//   imm32_3     in   32  EX/MEM extended immediate
//   ForwardRTM  in   1   1: store data is taken from WD (WB result); 0: taken from B3
//   WD          in   32  WB-stage write-back data (forwarding source)
//   PC4         out  32  MEM/WB PC
//   Instr4      out  32  MEM/WB instruction
//   Result4     out  32  MEM/WB ALU result
//   RD4         out  32  MEM/WB load data, already extended
//   WA4         out  5   MEM/WB destination register
//   imm32_4     out  32  MEM/WB immediate
// BEHAVIOUR
//   - Reset (sync, has priority): all MEM/WB outputs are 0; every DM word is 0.
//     A store that is present in the reset cycle is suppressed.
//   - Index: idx = Result3[DM_AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DM_WORDS*4.
//   - Decode on Instr3[31:26]:
//       sw 101011, sh 101001, sb 101000;
//       lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
//     Any other opcode leaves DM unchanged; RD4 captures 0.
//   - Store data SD = ForwardRTM ? WD : B3.
//   - Stores write on the rising edge:
//       sw -> whole word;
//       sh -> half at Result3[1] (1 = bits 31:16), data = SD[15:0];
//       sb -> byte at Result3[1:0] (3 = bits 31:24), data = SD[7:0];
//       other bytes are untouched.
//   - Load read is combinational from DM[idx]. The byte/half is selected by Result3[1:0]:
//       lb/lh sign-extend; lbu/lhu zero-extend.
//     The result is captured into RD4 on the edge, so load latency = 1 cycle (MEM -> WB).
//   - Store followed by a load to the same word in the next cycle returns the new data
//     (write completes at the earlier edge).
//   - Misaligned lw/sw (Result3[1:0]!=0) or lh/lhu/sh (Result3[0]!=0):
//     the low address bits are ignored and the access is treated as aligned.
//     No exception is raised.
//   - Passthrough regs update every non-reset edge: PC4<=PC3, Instr4<=Instr3, Result4<=Result3,
//     WA4<=WA3, imm32_4<=imm32_3. There is no stall or flush input; bubbles arrive as Instr3=0 (nop).
// CONFIGURATION
//   MEM_SUBWORD_EN defined:
//     sh/sb/lh/lhu/lb/lbu are supported as above.
//   MEM_SUBWORD_EN undefined:
//     only lw/sw are decoded; the subword opcodes behave as "other" (no write, RD4=0).
//     Byte-lane logic is not synthesised.
// STRUCTURE
//   - Opcode localparams (OP_LW, OP_SW, ...) and DM_WORDS default go in shared mips_defs package/header.
//     EX/ID controllers use the same header.
//   - Sub-module dm:
//       ports: clk, reset, we[3:0] byte enables, idx, wdata, rdata.
//       Synchronous write; asynchronous read; reset clears the array.
//   - Top holds: forwarding mux, store lane/byte-enable generation, load extension, MEM/WB register.
// TESTING
//   1. reset=1 for 2 cycles -> all outputs 0; lw from 0x0 afterwards -> RD4=0x00000000.
//   2. sw B3=0xDEADBEEF @0x10, then lw @0x10 next cycle -> RD4=0xDEADBEEF one cycle after lw is in MEM.
//   3. sw 0x11223344 @0x20; sb B3=0xAA @0x21; lw @0x20 -> 0x1122AA44;
//      lb @0x21 -> 0xFFFFFFAA; lbu @0x21 -> 0x000000AA.
//   4. sh B3=0x8001 @0x32; lh @0x32 -> 0xFFFF8001; lhu @0x32 -> 0x00008001;
//      lw @0x30 -> upper half 0x8001, lower half unchanged.
//   5. ForwardRTM=1, WD=0x12345678, B3=0 with sw @0x40 -> lw @0x40 returns 0x12345678.
//   6. sw @0x50 in the same cycle as reset=1 -> lw @0x50 returns 0.
//      Address 0x1050 with DM_WORDS=1024 aliases to 0x50.
//      MEM_SUBWORD_EN undefined: sb leaves memory unchanged.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: memory opcodes, data-memory sizing defaults, load-extension helpers.
// Used by the EX/ID controllers and the MEM stage.
package mips_defs;

  localparam int DM_WORDS_DEF = 1024;
  localparam int DM_AW_DEF    = 10;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/memory_stage_dm.sv
// Data memory: four byte lanes with per-lane write enable, synchronous write,
// combinational read and a synchronous clear on reset.
module dm
  import mips_defs::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW    = DM_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        we,
  input  logic [DM_AW-1:0]  idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem_reg [DM_WORDS];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DM_WORDS; i++) lane_mem_reg[i] <= '0;
        end else if (we[gi]) begin
          lane_mem_reg[idx] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = lane_mem_reg[idx];
    end
  endgenerate

endmodule

// File: rtl/memory_stage.sv
// MEM stage: store-data forwarding, byte-enable generation, load extension, MEM/WB register.
// Define MEM_SUBWORD_EN to add sh/sb/lh/lhu/lb/lbu; otherwise only lw/sw are decoded.
module memory_stage
  import mips_defs::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW    = DM_AW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC3,
  input  logic [31:0] Instr3,
  input  logic [31:0] Result3,
  input  logic [31:0] B3,
  input  logic [4:0]  WA3,
  input  logic [31:0] imm32_3,
  input  logic        ForwardRTM,
  input  logic [31:0] WD,
  output logic [31:0] PC4,
  output logic [31:0] Instr4,
  output logic [31:0] Result4,
  output logic [31:0] RD4,
  output logic [4:0]  WA4,
  output logic [31:0] imm32_4
);

  logic [5:0]       opcode;
  logic [31:0]      store_data;
  logic [DM_AW-1:0] idx;
  logic [3:0]       dm_we;
  logic [31:0]      dm_wdata;
  logic [31:0]      dm_rdata;
  logic [31:0]      load_next;

  assign opcode     = Instr3[31:26];
  assign store_data = ForwardRTM ? WD : B3;
  // Upper address bits are dropped, so accesses wrap modulo the memory size.
  assign idx        = Result3[DM_AW+1:2];

`ifdef MEM_SUBWORD_EN
  logic [1:0]  byte_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign byte_off = Result3[1:0];
  assign ld_byte  = 8'(dm_rdata >> {byte_off, 3'b000});
  assign ld_half  = Result3[1] ? dm_rdata[31:16] : dm_rdata[15:0];
`endif

  always_comb begin
    dm_we     = 4'b0000;
    dm_wdata  = store_data;
    load_next = '0;
    case (opcode)
      OP_SW: dm_we = 4'b1111;
      OP_LW: load_next = dm_rdata;
`ifdef MEM_SUBWORD_EN
      // Data is replicated across lanes; the byte enables pick the target lane.
      OP_SH: begin
        dm_wdata = {2{store_data[15:0]}};
        dm_we    = Result3[1] ? 4'b1100 : 4'b0011;
      end
      OP_SB: begin
        dm_wdata = {4{store_data[7:0]}};
        dm_we    = 4'b0001 << byte_off;
      end
      OP_LH:  load_next = ext_half(ld_half, 1'b1);
      OP_LHU: load_next = ext_half(ld_half, 1'b0);
      OP_LB:  load_next = ext_byte(ld_byte, 1'b1);
      OP_LBU: load_next = ext_byte(ld_byte, 1'b0);
`endif
      default: ;
    endcase
  end

  dm #(
    .DM_WORDS (DM_WORDS),
    .DM_AW    (DM_AW)
  ) u_dm (
    .clk   (clk),
    .reset (reset),
    .we    (dm_we),
    .idx   (idx),
    .wdata (dm_wdata),
    .rdata (dm_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      PC4     <= '0;
      Instr4  <= '0;
      Result4 <= '0;
      RD4     <= '0;
      WA4     <= '0;
      imm32_4 <= '0;
    end else begin
      PC4     <= PC3;
      Instr4  <= Instr3;
      Result4 <= Result3;
      RD4     <= load_next;
      WA4     <= WA3;
      imm32_4 <= imm32_3;
    end
  end

endmodule
